mem_access_ctrl: RTL and testbench

- Load/store initiator that drives the word-wide data memory stage (`memstage`: clk, we, addr[9:0], din[31:0], dout[31:0]) on behalf of the CPU pipeline.
- Accepts byte, halfword and word requests over a valid/ready handshake and returns one response per request.
- Sub-word stores are done as read-modify-write on the 32-bit RAM word.
- Loads are lane-extracted and sign- or zero-extended.

---
 rtl/mem_acc_pkg.sv | 47 ++++
 rtl/mem_access_ctrl_if.sv | 29 ++
 rtl/mem_lane_unit.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_acc_pkg.sv
// Shared types for the memory access controller: access sizes, FSM states
// and the address alignment helpers used at request accept.
package mem_acc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_e;

  // Size code 3 behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] s);
    case (s)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Clear the low address bits that a half or word access cannot use.
  function automatic logic [1:0] align_lo(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return {lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle of the memory access controller.
// The CPU drives the master modport, the controller uses the slave modport.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 10
);
  import mem_acc_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: load-side lane extraction with sign/zero
// extension, and store-side merge of the write lane into the old RAM word.
module mem_lane_unit
  import mem_acc_pkg::*;
(
  input  size_e             i_size,
  input  logic [1:0]        i_lane,
  input  logic              i_unsigned,
  input  logic [DATA_W-1:0] i_old_word,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, extend it, and build the merged store word.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_byte      = i_old_word[{i_lane, 3'b000} +: 8];
    w_half      = i_old_word[{i_lane[1], 4'b0000} +: 16];
    o_load_data = i_old_word;
    o_merged    = i_old_word;
    case (i_size)
      SZ_BYTE: begin
        o_load_data                     = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load_data                         = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: begin
        o_merged = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the word-wide memstage RAM. One request is in
// flight at a time; sub-word stores are read-modify-write. All outputs are
// registered. Optional misalignment trap: define MEM_ACC_MISALIGN_TRAP_EN.
module mem_access_ctrl
  import mem_acc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.slave   cpu_if,
  output logic               o_ram_we,
  output logic [ADDR_W-1:0]  o_ram_addr,
  output logic [DATA_W-1:0]  o_ram_din,
  input  logic [DATA_W-1:0]  i_ram_dout
);

  state_e            r_state, w_next_state;
  logic              r_we, r_unsigned;
  size_e             r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_req_ready, r_resp_valid, r_resp_err, r_ram_we;
  logic [DATA_W-1:0] r_resp_rdata, r_ram_din;
  logic [ADDR_W-1:0] r_ram_addr;

  logic              w_accept, w_trap, w_resp_err_nxt;
  size_e             w_req_size;
  logic [ADDR_W+1:0] w_req_addr;
  logic [DATA_W-1:0] w_resp_rdata_nxt, w_ram_din_nxt, w_load_data, w_merged;
  logic [ADDR_W-1:0] w_ram_addr_nxt;

  assign w_accept   = cpu_if.req_valid & r_req_ready;
  assign w_req_size = norm_size(cpu_if.req_size);

`ifdef MEM_ACC_MISALIGN_TRAP_EN
  assign w_trap     = is_misaligned(w_req_size, cpu_if.req_addr[1:0]);
  assign w_req_addr = cpu_if.req_addr;
`else
  assign w_trap     = 1'b0;
  assign w_req_addr = {cpu_if.req_addr[ADDR_W+1:2],
                       align_lo(w_req_size, cpu_if.req_addr[1:0])};
`endif

  mem_lane_unit u_lane (
    .i_size      (r_size),
    .i_lane      (r_addr[1:0]),
    .i_unsigned  (r_unsigned),
    .i_old_word  (i_ram_dout),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Latch the (aligned) request fields on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_we       <= cpu_if.req_we;
      r_unsigned <= cpu_if.req_unsigned;
      r_size     <= w_req_size;
      r_addr     <= w_req_addr;
      r_wdata    <= cpu_if.req_wdata;
    end
  end

  // Next state plus the next values of the data-carrying output registers.
  always_comb begin
    w_next_state     = r_state;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_din_nxt    = r_ram_din;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_resp_rdata_nxt = '0;
          w_resp_err_nxt   = 1'b0;
          if (w_trap) begin
            w_resp_err_nxt = 1'b1;
            w_next_state   = RESP;
          end else begin
            w_ram_addr_nxt = w_req_addr[ADDR_W+1:2];
            if (cpu_if.req_we && (w_req_size == SZ_WORD)) begin
              w_ram_din_nxt = cpu_if.req_wdata;
              w_next_state  = WR;
            end else begin
              w_next_state  = RD;
            end
          end
        end
      end
      RD: begin
        w_ram_addr_nxt = r_addr[ADDR_W+1:2];
        w_next_state   = RD_DATA;
      end
      RD_DATA: begin
        if (r_we) begin
          w_ram_din_nxt = w_merged;
          w_next_state  = WR;
        end else begin
          w_resp_rdata_nxt = w_load_data;
          w_next_state     = RESP;
        end
      end
      WR:      w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output registers, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
    end else begin
      r_req_ready  <= (w_next_state == IDLE);
      r_resp_valid <= (w_next_state == RESP);
      r_ram_we     <= (w_next_state == WR);
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_din    <= w_ram_din_nxt;
    end
  end

  assign cpu_if.req_ready  = r_req_ready;
  assign cpu_if.resp_valid = r_resp_valid;
  assign cpu_if.resp_rdata = r_resp_rdata;
  assign cpu_if.resp_err   = r_resp_err;
  assign o_ram_we          = r_ram_we;
  assign o_ram_addr        = r_ram_addr;
  assign o_ram_din         = r_ram_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, multi-cycle
// corner sequences (back-to-back, reset mid-access) and randomized requests
// checked against a byte-mask reference model of a 1024-word memory.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;

  logic [31:0] mem     [0:1023] = '{default: 32'h0};
  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_if     (bus),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .i_ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // memstage: synchronous read, write on we.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: memory as words, accesses as byte masks and shifts.
  function automatic void ref_model(input bit we, input logic [1:0] size, input bit uns,
                                    input logic [11:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output bit err, output int lat,
                                    output int nwr, output logic [31:0] din);
    int nbytes, off, widx;
    logic [63:0] mask64;
    logic [31:0] mask, old, v;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = int'(addr[1:0]);
    widx   = int'(addr[11:2]);
    rd = '0; err = 1'b0; nwr = 0; din = '0; lat = 0;
`ifdef MEM_ACC_MISALIGN_TRAP_EN
    if ((off % nbytes) != 0) begin
      err = 1'b1;
      lat = 1;
      return;
    end
`endif
    off    = off - (off % nbytes);
    mask64 = (64'd1 << (8 * nbytes)) - 64'd1;
    mask   = mask64[31:0];
    old    = ref_mem[widx];
    if (we) begin
      din           = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      ref_mem[widx] = din;
      nwr           = 1;
      lat           = (nbytes == 4) ? 2 : 4;
    end else begin
      v = (old >> (8 * off)) & mask;
      if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      rd  = v;
      lat = 3;
    end
  endfunction

  // One request with valid dropped after accept; observes until resp_valid.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err, output int lat,
                        output int nwr, output logic [31:0] din, output logic [9:0] waddr,
                        output bit busy_ok);
    int w = 0;
    rd = '0; err = 1'b0; lat = -1; nwr = 0; din = '0; waddr = '0; busy_ok = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) return;
    bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = 12'($urandom);
    bus.req_wdata    = $urandom;
    for (int c = 1; c <= 20; c++) begin
      if (ram_we) begin
        nwr++;
        din   = ram_din;
        waddr = ram_addr;
      end
      if (bus.req_ready) busy_ok = 1'b0;
      if (bus.resp_valid) begin
        lat = c;
        rd  = bus.resp_rdata;
        err = bus.resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input bit we, input logic [1:0] size, input bit uns,
                           input logic [11:0] addr, input logic [31:0] wd,
                           input logic [31:0] e_rd, input bit e_err, input int e_lat,
                           input int e_nwr, input logic [31:0] e_din);
    logic [31:0] rd, din;
    logic [9:0]  waddr;
    bit          err, busy_ok;
    int          lat, nwr;
    do_req(we, size, uns, addr, wd, rd, err, lat, nwr, din, waddr, busy_ok);
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".rdata"}, rd, e_rd);
    check({tag, ".err"}, err, e_err);
    check({tag, ".ram_we_pulses"}, nwr, e_nwr);
    check({tag, ".ready_low_busy"}, busy_ok, 1);
    if (e_nwr > 0) begin
      check({tag, ".ram_din"}, din, e_din);
      check({tag, ".ram_addr"}, waddr, addr[11:2]);
    end
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_nwr;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs [18];

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] wdata;
  } req_t;

  initial begin
    logic [31:0] m_rd, m_din;
    bit          m_err;
    int          m_lat, m_nwr;
    req_t        bb [3];
    logic [31:0] got [$];
    logic [31:0] exp_bb [3];

    vecs[0]  = '{1, 2'd2, 0, 12'h030, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF};
    vecs[1]  = '{0, 2'd2, 0, 12'h030, 32'h0,        32'hDEADBEEF, 0, 3, 0, 32'h0};
    vecs[2]  = '{1, 2'd0, 0, 12'h032, 32'hFFFFAB55, 32'h0,        0, 4, 1, 32'hDE55BEEF};
    vecs[3]  = '{0, 2'd0, 0, 12'h033, 32'h0,        32'hFFFFFFDE, 0, 3, 0, 32'h0};
    vecs[4]  = '{0, 2'd0, 1, 12'h033, 32'h0,        32'h000000DE, 0, 3, 0, 32'h0};
    vecs[5]  = '{0, 2'd1, 0, 12'h030, 32'h0,        32'hFFFFBEEF, 0, 3, 0, 32'h0};
    vecs[6]  = '{0, 2'd1, 1, 12'h032, 32'h0,        32'h0000DE55, 0, 3, 0, 32'h0};
    vecs[7]  = '{0, 2'd0, 0, 12'h032, 32'h0,        32'h00000055, 0, 3, 0, 32'h0};
    vecs[8]  = '{1, 2'd1, 0, 12'h036, 32'h1234ABCD, 32'h0,        0, 4, 1, 32'hABCD0000};
    vecs[9]  = '{1, 2'd0, 0, 12'h034, 32'h0000007F, 32'h0,        0, 4, 1, 32'hABCD007F};
    vecs[10] = '{0, 2'd3, 0, 12'h034, 32'h0,        32'hABCD007F, 0, 3, 0, 32'h0};
    vecs[11] = '{0, 2'd0, 0, 12'h035, 32'h0,        32'h00000000, 0, 3, 0, 32'h0};
    vecs[12] = '{0, 2'd1, 0, 12'h036, 32'h0,        32'hFFFFABCD, 0, 3, 0, 32'h0};
`ifdef MEM_ACC_MISALIGN_TRAP_EN
    vecs[13] = '{0, 2'd2, 0, 12'h031, 32'h0,        32'h0,        1, 1, 0, 32'h0};
    vecs[14] = '{1, 2'd1, 0, 12'h037, 32'h00005AA5, 32'h0,        1, 1, 0, 32'h0};
    vecs[15] = '{0, 2'd2, 0, 12'h034, 32'h0,        32'hABCD007F, 0, 3, 0, 32'h0};
`else
    vecs[13] = '{0, 2'd2, 0, 12'h031, 32'h0,        32'hDE55BEEF, 0, 3, 0, 32'h0};
    vecs[14] = '{1, 2'd1, 0, 12'h037, 32'h00005AA5, 32'h0,        0, 4, 1, 32'h5AA5007F};
    vecs[15] = '{0, 2'd2, 0, 12'h034, 32'h0,        32'h5AA5007F, 0, 3, 0, 32'h0};
`endif
    vecs[16] = '{1, 2'd2, 0, 12'hFFC, 32'hCAFEF00D, 32'h0,        0, 2, 1, 32'hCAFEF00D};
    vecs[17] = '{0, 2'd0, 1, 12'hFFF, 32'h0,        32'h000000CA, 0, 3, 0, 32'h0};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.req_ready", bus.req_ready, 1);
    check("rst.resp_valid", bus.resp_valid, 0);
    check("rst.resp_err", bus.resp_err, 0);
    check("rst.resp_rdata", bus.resp_rdata, 0);
    check("rst.ram_we", ram_we, 0);
    check("rst.ram_addr", ram_addr, 0);
    check("rst.ram_din", ram_din, 0);
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      ref_model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                m_rd, m_err, m_lat, m_nwr, m_din);
      run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat,
                vecs[i].exp_nwr, vecs[i].exp_din);
    end

    // Back-to-back: req_valid held high across three requests
    begin
      int k = 0, n_resp = 0, n_we = 0, extra = 0;
      bit ready_ok = 1'b1;
      bb[0] = '{1, 2'd2, 0, 12'h040, 32'h11223344};
      bb[1] = '{0, 2'd0, 0, 12'h041, 32'h0};
      bb[2] = '{0, 2'd1, 1, 12'h042, 32'h0};
      foreach (bb[i]) begin
        ref_model(bb[i].we, bb[i].size, bb[i].uns, bb[i].addr, bb[i].wdata,
                  m_rd, m_err, m_lat, m_nwr, m_din);
        exp_bb[i] = m_rd;
      end
      @(negedge clk);
      for (int c = 0; c < 60 && n_resp < 3; c++) begin
        if (ram_we) n_we++;
        if (bus.resp_valid) begin
          got.push_back(bus.resp_rdata);
          n_resp++;
          if (bus.req_ready) ready_ok = 1'b0;
        end
        if (k < 3) begin
          bus.req_we = bb[k].we; bus.req_size = bb[k].size; bus.req_unsigned = bb[k].uns;
          bus.req_addr = bb[k].addr; bus.req_wdata = bb[k].wdata; bus.req_valid = 1'b1;
          if (bus.req_ready) k++;
        end else begin
          bus.req_valid = 1'b0;
        end
        @(negedge clk);
      end
      bus.req_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (bus.resp_valid) extra++;
        @(negedge clk);
      end
      check("b2b.resp_count", n_resp + extra, 3);
      check("b2b.ram_we_pulses", n_we, 1);
      check("b2b.ready_low_in_resp", ready_ok, 1);
      check("b2b.rdata_const1", (got.size() > 1) ? got[1] : 32'hX, 32'h00000033);
      for (int i = 0; i < 3; i++)
        check($sformatf("b2b.rdata%0d", i), (got.size() > i) ? got[i] : 32'hX, exp_bb[i]);
    end

    // Reset during RD_DATA of a byte store: aborted, RAM untouched
    begin
      int n_we = 0, n_resp = 0;
      @(negedge clk);
      bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
      bus.req_addr = 12'h031; bus.req_wdata = 32'h000000AA; bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (ram_we) n_we++;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst.req_ready_async", bus.req_ready, 1);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (c == 2) rst_n = 1'b1;
        if (ram_we) n_we++;
        if (bus.resp_valid) n_resp++;
      end
      check("mid_rst.ram_we_pulses", n_we, 0);
      check("mid_rst.resp_pulses", n_resp, 0);
      check("mid_rst.req_ready", bus.req_ready, 1);
      check("mid_rst.ram_word12", mem[12], 32'hDE55BEEF);
      check("mid_rst.ram_addr", ram_addr, 0);
    end

    // Reset while ram_we is high: it drops at once and the write is lost
    begin
      @(negedge clk);
      bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
      bus.req_addr = 12'h050; bus.req_wdata = 32'h0BADF00D; bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("wr_rst.ram_we_before", ram_we, 1);
      rst_n = 1'b0;
      #1;
      check("wr_rst.ram_we_async", ram_we, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("wr_rst.ram_word20", mem[20], 32'h0);
    end

    ref_model(0, 2'd2, 0, 12'h030, 32'h0, m_rd, m_err, m_lat, m_nwr, m_din);
    run_check("post_rst_load", 0, 2'd2, 0, 12'h030, 32'h0, m_rd, m_err, m_lat, m_nwr, m_din);

    // Randomized requests against the reference model
    for (int i = 0; i < 300; i++) begin
      bit          r_we, r_uns;
      logic [1:0]  r_size, r_lo;
      logic [9:0]  r_widx;
      logic [11:0] r_addr;
      logic [31:0] r_wd;
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_lo   = 2'($urandom_range(0, 3));
      r_widx = 10'($urandom_range(0, 15));
      r_addr = {r_widx, r_lo};
      r_wd   = $urandom;
      ref_model(r_we, r_size, r_uns, r_addr, r_wd, m_rd, m_err, m_lat, m_nwr, m_din);
      run_check($sformatf("rnd%0d", i), r_we, r_size, r_uns, r_addr, r_wd,
                m_rd, m_err, m_lat, m_nwr, m_din);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
